// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among NUM_REQ requesters; define ALU_ARB_PERF_EN for busy/ops counters
module alu_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int XLEN          = 32,
  parameter int ALUCTRL_WIDTH = 4,
  parameter int ALU_LATENCY   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*XLEN-1:0]          req_a_i,
  input  logic [NUM_REQ*XLEN-1:0]          req_b_i,
  input  logic [NUM_REQ*ALUCTRL_WIDTH-1:0] req_ctrl_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic [XLEN-1:0]                  rsp_data_o,
  output logic [XLEN-1:0]                  alu_a_o,
  output logic [XLEN-1:0]                  alu_b_o,
  output logic [ALUCTRL_WIDTH-1:0]         aluctrl_o,
`ifdef ALU_ARB_PERF_EN
  output logic [31:0]                      perf_busy_o,
  output logic [31:0]                      perf_ops_o,
`endif
  input  logic [XLEN-1:0]                  alu_out_i
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int LW = ALU_LATENCY > 0 ? $clog2(ALU_LATENCY + 1) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [PW-1:0] rr_ptr, owner, winner;
  logic [LW-1:0] lat_cnt;
  logic grant, done;
  int best;
  // pick the valid requester closest to rr_ptr going upward with wrap
  always_comb begin
    winner = '0;
    best = NUM_REQ;
    for (int k = 0; k < NUM_REQ; k++)
      if (req_valid_i[k] && ((k - int'(rr_ptr) + NUM_REQ) % NUM_REQ) < best) begin
        best = (k - int'(rr_ptr) + NUM_REQ) % NUM_REQ;
        winner = PW'(k);
      end
  end
  assign grant       = state == IDLE && !rst && |req_valid_i;
  assign req_ready_o = grant ? NUM_REQ'(1) << winner : '0;
  assign rsp_valid_o = state == RESP ? NUM_REQ'(1) << owner : '0;
  assign done        = |(rsp_valid_o & rsp_ready_i);
  // next-state: grant leaves IDLE, latency expiry leaves EXEC, owner handshake leaves RESP
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (grant ? EXEC : IDLE) :
              state == EXEC ? (lat_cnt == '0 ? RESP : EXEC) :
              (done ? IDLE : RESP);
  end
  // state register; reset drops any in-flight op
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // operand capture on grant, latency countdown and result capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr     <= '0;
      owner      <= '0;
      lat_cnt    <= '0;
      alu_a_o    <= '0;
      alu_b_o    <= '0;
      aluctrl_o  <= '0;
      rsp_data_o <= '0;
    end else begin
      if (grant) begin
        alu_a_o   <= req_a_i[winner*XLEN +: XLEN];
        alu_b_o   <= req_b_i[winner*XLEN +: XLEN];
        aluctrl_o <= req_ctrl_i[winner*ALUCTRL_WIDTH +: ALUCTRL_WIDTH];
        owner     <= winner;
        rr_ptr    <= winner == PW'(NUM_REQ - 1) ? '0 : winner + 1'b1;
        lat_cnt   <= LW'(ALU_LATENCY);
      end
      if (state == EXEC && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      if (state == EXEC && lat_cnt == '0) rsp_data_o <= alu_out_i;
    end
`ifdef ALU_ARB_PERF_EN
  // saturating busy-cycle and completed-op counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_busy_o <= '0;
      perf_ops_o  <= '0;
    end else begin
      if (state != IDLE && ~&perf_busy_o) perf_busy_o <= perf_busy_o + 1'b1;
      if (done && ~&perf_ops_o) perf_ops_o <= perf_ops_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven and scoreboard checks of alu_arbiter at ALU_LATENCY 1 and 0
module tb_alu_arbiter;
  localparam int N = 4;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N-1:0] req_valid1 = '0, req_ready1, rsp_valid1, rsp_ready1 = '1;
  logic [N*32-1:0] req_a = '0, req_b = '0;
  logic [N*4-1:0] req_ctrl = '0;
  logic [31:0] rsp_data, alu_a, alu_b, alu_q = '0;
  logic [31:0] rsp_data1, alu_a1, alu_b1, alu_out1;
  logic [3:0] alu_c, alu_c1;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] busy0, ops0, busy1, ops1;
`endif
  function automatic logic [31:0] alu_f(input logic [31:0] a, b, input logic [3:0] c);
    logic signed [31:0] s;
    s = $signed(a) >>> b[4:0];
    if (c == 4'd0) return a + b;
    if (c == 4'd1) return a - b;
    if (c == 4'd2) return a ^ b;
    if (c == 4'd3) return s;
    return a & b;
  endfunction
  always @(posedge clk) alu_q <= alu_f(alu_a, alu_b, alu_c);
  assign alu_out1 = alu_f(alu_a1, alu_b1, alu_c1);
  alu_arbiter #(.NUM_REQ(N), .XLEN(32), .ALUCTRL_WIDTH(4), .ALU_LATENCY(1)) u0 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_ctrl_i(req_ctrl),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .aluctrl_o(alu_c),
`ifdef ALU_ARB_PERF_EN
    .perf_busy_o(busy0), .perf_ops_o(ops0),
`endif
    .alu_out_i(alu_q));
  alu_arbiter #(.NUM_REQ(N), .XLEN(32), .ALUCTRL_WIDTH(4), .ALU_LATENCY(0)) u1 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid1), .req_ready_o(req_ready1),
    .req_a_i(req_a), .req_b_i(req_b), .req_ctrl_i(req_ctrl),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1), .rsp_data_o(rsp_data1),
    .alu_a_o(alu_a1), .alu_b_o(alu_b1), .aluctrl_o(alu_c1),
`ifdef ALU_ARB_PERF_EN
    .perf_busy_o(busy1), .perf_ops_o(ops1),
`endif
    .alu_out_i(alu_out1));
  typedef struct {int r; logic [31:0] d;} exp_t;
  typedef struct {int r; logic [31:0] a, b; logic [3:0] c; logic [31:0] e; int bp;} vec_t;
  exp_t sb[$];
  vec_t tbl[5];
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input int r, input logic [31:0] a, b, input logic [3:0] c);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_ctrl[r*4 +: 4] = c;
  endtask
  task automatic wait_grant(input int r, input logic [31:0] e);
    int n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    chk("grant", 32'(req_ready), 32'(N'(1) << r));
    sb.push_back('{r, e});
  endtask
  task automatic wait_rsp(input int lat);
    int n = 1;
    exp_t x;
    while (rsp_valid == '0 && n < 20) begin @(negedge clk); #1; n++; end
    chk("rsp_latency", 32'(n), 32'(lat));
    x = sb.pop_front();
    chk("rsp_owner", 32'(rsp_valid), 32'(N'(1) << x.r));
    chk("rsp_data", rsp_data, x.d);
  endtask
  task automatic run_op(input vec_t v);
    @(negedge clk);
    drive(v.r, v.a, v.b, v.c);
    req_valid[v.r] = 1'b1;
    #1;
    wait_grant(v.r, v.e);
    @(negedge clk);
    req_valid[v.r] = 1'b0;
    #1;
    chk("exec_ready", 32'(req_ready), 0);
    chk("alu_a_held", alu_a, v.a);
    chk("alu_b_held", alu_b, v.b);
    wait_rsp(3);
    repeat (v.bp) begin
      req_valid[(v.r + 1) % N] = 1'b1;
      rsp_ready = ~(N'(1) << v.r);
      @(negedge clk);
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'(N'(1) << v.r));
      chk("bp_data", rsp_data, v.e);
      chk("bp_no_grant", 32'(req_ready), 0);
    end
    req_valid = '0;
    rsp_ready = N'(1) << v.r;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    chk("idle_after", 32'(rsp_valid), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{0, 32'd5, 32'd7, 4'd0, 32'd12, 0};
    tbl[1] = '{2, 32'h8000_0000, 32'd4, 4'd3, 32'hF800_0000, 5};
    tbl[2] = '{1, 32'h0000_F0F0, 32'h0000_0FF0, 4'd2, 32'h0000_FF00, 0};
    tbl[3] = '{3, 32'hDEAD_BEEF, 32'h0000_FFFF, 4'd4, 32'h0000_BEEF, 1};
    tbl[4] = '{1, 32'd3, 32'd10, 4'd1, 32'hFFFF_FFF9, 2};
    #2 rst = 1;
    #10;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_c", 32'(alu_c), 0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 5; i++) run_op(tbl[i]);
    // round robin with every requester valid and ready
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    for (int r = 0; r < N; r++) drive(r, 32'd10, 32'd3, 4'd1);
    req_valid = '1;
    rsp_ready = '1;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(k % N, 32'd7);
      @(negedge clk);
      #1;
      wait_rsp(3);
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = '0;
    // rr_ptr is now 1; only requester 3 valid, then pointer must wrap to 0
    run_op('{3, 32'd1, 32'd2, 4'd0, 32'd3, 0});
    @(negedge clk);
    drive(0, 32'd20, 32'd22, 4'd0);
    drive(1, 32'd1, 32'd1, 4'd0);
    req_valid = 4'b0011;
    rsp_ready = '1;
    #1;
    wait_grant(0, 32'd42);
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_rsp(3);
    @(negedge clk);
    rsp_ready = '0;
    // reset during EXEC drops the op
    drive(1, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd2);
    req_valid[1] = 1'b1;
    #1;
    chk("mid_grant", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    req_valid = '0;
    rsp_ready = '1;
    #1;
    rst = 1;
    #1;
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_alu_c", 32'(alu_c), 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    @(negedge clk) rst = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      chk("mid_no_rsp", 32'(rsp_valid), 0);
    end
    rsp_ready = '0;
    run_op('{2, 32'd9, 32'd4, 4'd1, 32'd5, 0});
    // zero-latency instance, immediate response ready
    for (int i = 0; i < 10; i++) begin
      int n;
      @(negedge clk);
      drive(i % N, 32'(i), 32'd100, 4'd0);
      req_valid1[i % N] = 1'b1;
      #1;
      n = 0;
      while (req_ready1 == '0 && n < 20) begin @(negedge clk); #1; n++; end
      chk("l0_grant", 32'(req_ready1), 32'(N'(1) << (i % N)));
      @(negedge clk);
      req_valid1 = '0;
      #1;
      n = 1;
      while (rsp_valid1 == '0 && n < 20) begin @(negedge clk); #1; n++; end
      chk("l0_latency", 32'(n), 2);
      chk("l0_owner", 32'(rsp_valid1), 32'(N'(1) << (i % N)));
      chk("l0_data", rsp_data1, 32'(i + 100));
    end
    @(negedge clk);
    #1;
    chk("l0_idle", 32'(rsp_valid1), 0);
`ifdef ALU_ARB_PERF_EN
    chk("perf_ops", ops1, 32'd10);
    chk("perf_busy", busy1, 32'd20);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one `alu` instance between NUM_REQ requesters (e.g. integer pipe, address-gen, debug unit) using round-robin arbitration. Each requester uses a valid/ready request channel and a valid/ready response channel. The block captures the winning operands, drives the ALU, waits a fixed ALU latency, then holds the result for the winner until it is accepted. The block sits between requesters and the `alu` ports `alu_a_i`, `alu_b_i`, `aluctrl_ctrl_i` and `alu_out_o`.

Parameters:
NUM_REQ, 4, number of requesters (1..8)
XLEN, 32, operand/result width
ALUCTRL_WIDTH, 4, ALU op code width (codes passed through unchanged)
ALU_LATENCY, 1, cycles from ALU input change to valid `alu_out_o` (0 = combinational)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid_i  input  NUM_REQ  per-requester request valid
req_ready_o  output  NUM_REQ  per-requester request accept (one-hot or zero)
req_a_i  input  NUM_REQ*XLEN  operand A, requester k at [k*XLEN +: XLEN]
req_b_i  input  NUM_REQ*XLEN  operand B, same packing
req_ctrl_i  input  NUM_REQ*ALUCTRL_WIDTH  op code, same packing
rsp_valid_o  output  NUM_REQ  per-requester result valid (one-hot or zero)
rsp_ready_i  input  NUM_REQ  per-requester result accept
rsp_data_o  output  XLEN  result, shared bus, meaningful only with rsp_valid_o
alu_a_o  output  XLEN  to ALU operand A
alu_b_o  output  XLEN  to ALU operand B
aluctrl_o  output  ALUCTRL_WIDTH  to ALU op code
alu_out_i  input  XLEN  from ALU result

Behaviour:
- Reset (async, any time, including mid-op):
  - state=IDLE; rr_ptr=0; owner=0; lat_cnt=0.
  - alu_a_o, alu_b_o, aluctrl_o, rsp_data_o = 0; req_ready_o=0; rsp_valid_o=0.
  - An in-flight op is dropped; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first k with req_valid_i[k], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready_o[winner]=1, driven combinationally from req_valid_i in IDLE only. All other bits are 0. No valid requests: all 0.
  - Handshake (valid&ready) at edge: capture A/B/ctrl of winner into alu_*_o registers; owner=winner; rr_ptr=(winner+1) mod NUM_REQ; lat_cnt=ALU_LATENCY; go EXEC.
- EXEC:
  - alu_*_o held stable; req_ready_o=0.
  - If lat_cnt!=0, decrement.
  - If lat_cnt==0, rsp_data_o<=alu_out_i and go RESP.
  - EXEC lasts ALU_LATENCY+1 cycles.
- RESP:
  - rsp_valid_o[owner]=1; rsp_data_o stable.
  - On rsp_ready_i[owner], go IDLE. rsp_ready_i of non-owners is ignored.
- Latency:
  - Accept edge at cycle t → rsp_valid_o high in cycle t+2+ALU_LATENCY (t+3 at default).
  - Minimum issue interval is ALU_LATENCY+3 cycles; one op outstanding at a time.
- Requester rules:
  - Requester rule: req_valid_i and operands stay stable until ready.
  - A requester may deassert valid before grant; it is then simply not selected.
- rr_ptr only advances on a grant. An idle requester costs no slot.
- Simultaneous rsp_ready_i with rsp_valid_o rising: completes in that cycle; IDLE next cycle; new grant is possible on the following edge.
- NUM_REQ=1: degenerates to a single-requester sequencer; rr_ptr stays 0.
- alu_*_o retain last issued values outside EXEC. No X on any output after reset.

Optional Feature:
Macro ALU_ARB_PERF_EN.
- Defined:
  - Adds output perf_busy_o [31:0], counting cycles with state!=IDLE.
  - Adds output perf_ops_o [31:0], counting completed response handshakes.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single op: rst pulse, then req0 A=5 B=7 ctrl=0000 (ADD), rsp_ready_i[0]=1 → req_ready_o[0] at t; rsp_valid_o=0001 at t+3; rsp_data_o=12; IDLE at t+4.
- Round-robin: req_valid_i=1111 held, SUB 10-3 from all, rsp_ready_i=1111 → grant order 0,1,2,3,0; each rsp_data_o=7; rsp_valid_o one-hot matching owner.
- Backpressure: req2 SRA A=0x80000000 B=4, rsp_ready_i[2]=0 for 5 cycles → rsp_valid_o[2] and rsp_data_o=0xF8000000 held stable; no new grant until ready.
- Skip idle: rr_ptr=1 after grant 0, only req3 valid → req3 granted next; rr_ptr becomes 0.
- Reset mid-op: assert rst during EXEC of req1 XOR → all outputs 0 immediately; no rsp_valid_o ever for that op; the next request is granted normally.
- ALU_LATENCY=0 build plus ALU_ARB_PERF_EN, 10 ops with immediate ready → rsp at t+2; perf_ops_o=10; perf_busy_o=20.
